issue_select_bank: RTL and testbench



---
 rtl/issue_select_bank_if.sv | 54 +++++
 rtl/issue_select_bank.sv | 178 +++++++++++++++++
 tb/tb_issue_select_bank.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_select_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_bank_if (with package issue_select_pkg)
// Description : RS entry type and the bus between one reservation-station
//               bank and its issue selector.
//                 master : RS / issue-stage side. Drives mispredict,
//                          rs_entries and fu_grants. Receives the clear
//                          outputs and the issue register.
//                 slave  : selector side.
// Revision    : 1.0 - initial release
// ============================================================================

package issue_select_pkg;
    localparam int ROB_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic                 src1_ready;
        logic                 src2_ready;
        logic                 rob_wrap;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [15:0]          payload;
    } rs_entry_t;
endpackage

interface issue_select_bank_if #(
    parameter int N_ENTRIES = 8,
    parameter int N_ISSUE   = 2
);
    import issue_select_pkg::*;

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int CNT_W = $clog2(N_ISSUE + 1);

    logic               mispredict;
    rs_entry_t          rs_entries [N_ENTRIES];
    logic [N_ISSUE-1:0] fu_grants;
    logic [N_ISSUE-1:0] issue_clear_valid;
    logic [IDX_W-1:0]   issue_clear_idx [N_ISSUE];
    rs_entry_t          issue_entries [N_ISSUE];
    logic [CNT_W-1:0]   issue_count;

    modport master (
        output mispredict, rs_entries, fu_grants,
        input  issue_clear_valid, issue_clear_idx, issue_entries, issue_count
    );

    modport slave (
        input  mispredict, rs_entries, fu_grants,
        output issue_clear_valid, issue_clear_idx, issue_entries, issue_count
    );
endinterface

`default_nettype wire

// File: rtl/issue_select_bank.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_bank
// Description : Per-category issue selector. Picks up to N_ISSUE ready
//               entries from one RS bank, one per granted FU slot. Returns
//               combinational clear indices. Registers the picks into the
//               issue register.
//               Ranking is chosen with the ISSUE_AGE_ORDER_EN macro:
//                 defined   : oldest-first by (rob_wrap, rob_idx).
//                 undefined : round-robin starting at rr_q.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous, active-high
//               sel_if  - issue_select_bank_if.slave, which carries:
//                         mispredict, rs_entries and fu_grants (in);
//                         issue_clear_valid / issue_clear_idx (comb out);
//                         issue_entries / issue_count (registered out)
// Revision    : 1.0 - initial release
// ============================================================================

module issue_select_bank #(
    parameter  int N_ENTRIES = 8,
    parameter  int N_ISSUE   = 2,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    issue_select_bank_if.slave  sel_if
);
    import issue_select_pkg::*;

    localparam int CNT_W = $clog2(N_ISSUE + 1);
    localparam int ORD_W = IDX_W + 1;

    logic [N_ENTRIES-1:0] ready;
    logic [IDX_W-1:0]     rank [N_ENTRIES];
    logic [N_ISSUE-1:0]   clear_valid;
    logic [IDX_W-1:0]     clear_idx [N_ISSUE];
    rs_entry_t            entries_d [N_ISSUE];
    rs_entry_t            entries_q [N_ISSUE];
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     count_q;

`ifdef ISSUE_AGE_ORDER_EN
    // a is older than b. Differing wraps mean b's ROB index already wrapped.
    function automatic logic older(input rs_entry_t a, input rs_entry_t b);
        if (a.rob_wrap == b.rob_wrap) begin
            return a.rob_idx < b.rob_idx;
        end
        return a.rob_idx > b.rob_idx;
    endfunction
`else
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;

    // Distance of idx from the round-robin start, walking upward with wrap.
    function automatic logic [IDX_W:0] rr_pos(input int idx, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] i_ext;
        i_ext = (IDX_W+1)'(idx);
        if (i_ext >= {1'b0, ptr}) begin
            return i_ext - {1'b0, ptr};
        end
        return i_ext + (IDX_W+1)'(N_ENTRIES) - {1'b0, ptr};
    endfunction
`endif

    always_comb begin : p_ready
        for (int i = 0; i < N_ENTRIES; i++) begin
            ready[i] = sel_if.rs_entries[i].valid & sel_if.rs_entries[i].src1_ready
                     & sel_if.rs_entries[i].src2_ready;
        end
    end

    // rank[i] = number of ready entries that beat entry i. Ranks are only
    // meaningful for ready entries.
    always_comb begin : p_rank
        for (int i = 0; i < N_ENTRIES; i++) begin
            rank[i] = '0;
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (j != i && ready[j]) begin
`ifdef ISSUE_AGE_ORDER_EN
                    if (older(sel_if.rs_entries[j], sel_if.rs_entries[i]) ||
                        (!older(sel_if.rs_entries[i], sel_if.rs_entries[j]) && j < i)) begin
                        rank[i] = rank[i] + IDX_W'(1);
                    end
`else
                    if (rr_pos(j, rr_q) < rr_pos(i, rr_q)) begin
                        rank[i] = rank[i] + IDX_W'(1);
                    end
`endif
                end
            end
        end
    end

    // The n-th granted slot takes the ready entry of rank n. Each entry has
    // a single rank, so two slots can never clear the same index. The
    // first-match guard keeps each slot one-hot even if ranks collide.
    always_comb begin : p_select
        logic [ORD_W-1:0] ord;
        logic             found;
        ord   = '0;
        found = 1'b0;
        for (int k = 0; k < N_ISSUE; k++) begin
            found          = 1'b0;
            clear_valid[k] = 1'b0;
            clear_idx[k]   = '0;
            entries_d[k]   = '0;
            if (sel_if.fu_grants[k]) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (!found && ready[i] && ({1'b0, rank[i]} == ord)) begin
                        found        = 1'b1;
                        clear_idx[k] = IDX_W'(i);
                        entries_d[k] = sel_if.rs_entries[i];
                    end
                end
                ord = ord + ORD_W'(1);
            end
            if (found && !sel_if.mispredict && !reset) begin
                clear_valid[k] = 1'b1;
            end else begin
                clear_idx[k] = '0;
                entries_d[k] = '0;
            end
        end
    end

    always_comb begin : p_count
        count_d = '0;
        for (int k = 0; k < N_ISSUE; k++) begin
            if (clear_valid[k]) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin : p_issue_reg
        if (reset) begin
            for (int k = 0; k < N_ISSUE; k++) begin
                entries_q[k] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int k = 0; k < N_ISSUE; k++) begin
                entries_q[k] <= entries_d[k];
            end
            count_q <= count_d;
        end
    end

`ifndef ISSUE_AGE_ORDER_EN
    // The highest valid slot holds the lowest-priority pick. The next scan
    // starts just past it.
    always_comb begin : p_rr_next
        rr_d = rr_q;
        for (int k = 0; k < N_ISSUE; k++) begin
            if (clear_valid[k]) begin
                rr_d = (clear_idx[k] == IDX_W'(N_ENTRIES - 1)) ? '0 : clear_idx[k] + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin : p_rr_reg
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign sel_if.issue_clear_valid = clear_valid;
    assign sel_if.issue_clear_idx   = clear_idx;
    assign sel_if.issue_entries     = entries_q;
    assign sel_if.issue_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_select_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_select_bank
// Description : Self-checking bench for issue_select_bank (8 entries,
//               2 slots). Ranking expectations follow ISSUE_AGE_ORDER_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_issue_select_bank;
    import issue_select_pkg::*;

    localparam int NE = 8;
    localparam int NI = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    issue_select_bank_if #(.N_ENTRIES(NE), .N_ISSUE(NI)) sel_bus ();

    issue_select_bank #(.N_ENTRIES(NE), .N_ISSUE(NI)) dut (
        .clock  (clock),
        .reset  (reset),
        .sel_if (sel_bus)
    );

    typedef struct packed {
        logic [7:0] vm;
        logic [7:0] rm;
        logic [1:0] g;
        logic       mp;
        logic [1:0] ecv;
        logic [2:0] ei0;
        logic [2:0] ei1;
    } vec_t;

    typedef struct packed {
        logic [1:0] cv;
        logic [1:0] cnt;
        rs_entry_t  e0;
        rs_entry_t  e1;
    } exp_reg_t;

    vec_t     vecs [$];
    exp_reg_t sb [$];
    int       n_cmp = 0;
    int       n_err = 0;

    logic [4:0] rob_i [NE];
    logic       rob_w [NE];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Valid-but-unready entries miss exactly one source operand.
    function automatic rs_entry_t mk_entry(input int i, input logic [7:0] vm, input logic [7:0] rm);
        rs_entry_t e;
        e.valid      = vm[i];
        e.src1_ready = rm[i] | (i % 2 == 0);
        e.src2_ready = rm[i] | (i % 2 == 1);
        e.rob_wrap   = rob_w[i];
        e.rob_idx    = rob_i[i];
        e.payload    = 16'hA000 | 16'(i);
        return e;
    endfunction

    task automatic set_default_rob();
        logic [4:0] pat [NE];
        pat = '{5'd7, 5'd3, 5'd12, 5'd1, 5'd9, 5'd0, 5'd5, 5'd14};
        for (int i = 0; i < NE; i++) begin
            rob_i[i] = pat[i];
            rob_w[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic [7:0] vm, input logic [7:0] rm, input logic [1:0] g, input logic mp);
        for (int i = 0; i < NE; i++) begin
            sel_bus.rs_entries[i] = mk_entry(i, vm, rm);
        end
        sel_bus.fu_grants  = g;
        sel_bus.mispredict = mp;
    endtask

    task automatic pop_check(input string tag);
        exp_reg_t x;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        chk({tag, " issue_count"}, 64'(sel_bus.issue_count), 64'(x.cnt));
        chk({tag, " slot0 valid"}, 64'(sel_bus.issue_entries[0].valid), 64'(x.cv[0]));
        chk({tag, " slot1 valid"}, 64'(sel_bus.issue_entries[1].valid), 64'(x.cv[1]));
        if (x.cv[0]) chk({tag, " slot0 entry"}, 64'(sel_bus.issue_entries[0]), 64'(x.e0));
        if (x.cv[1]) chk({tag, " slot1 entry"}, 64'(sel_bus.issue_entries[1]), 64'(x.e1));
    endtask

    task automatic step(input string tag, input logic [7:0] vm, input logic [7:0] rm,
                        input logic [1:0] g, input logic mp, input logic [1:0] ecv,
                        input logic [2:0] ei0, input logic [2:0] ei1);
        exp_reg_t x;
        @(negedge clock);
        pop_check({tag, " (prev reg)"});
        drive(vm, rm, g, mp);
        #1;
        chk({tag, " clear_valid"}, 64'(sel_bus.issue_clear_valid), 64'(ecv));
        chk({tag, " clear_idx0"}, 64'(sel_bus.issue_clear_idx[0]), 64'(ei0));
        chk({tag, " clear_idx1"}, 64'(sel_bus.issue_clear_idx[1]), 64'(ei1));
        x.cv  = ecv;
        x.cnt = 2'(ecv[0]) + 2'(ecv[1]);
        x.e0  = ecv[0] ? mk_entry(int'(ei0), vm, rm) : '0;
        x.e1  = ecv[1] ? mk_entry(int'(ei1), vm, rm) : '0;
        sb.push_back(x);
    endtask

    task automatic add(input logic [7:0] vm, input logic [7:0] rm, input logic [1:0] g,
                       input logic mp, input logic [1:0] ecv, input logic [2:0] ei0,
                       input logic [2:0] ei1);
        vec_t v;
        v.vm = vm; v.rm = rm; v.g = g; v.mp = mp;
        v.ecv = ecv; v.ei0 = ei0; v.ei1 = ei1;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        set_default_rob();
        drive(8'hFF, 8'hFF, 2'b11, 1'b0);

        // Reset state, with ready entries and grants present.
        #3 reset = 1'b1;
        #1;
        chk("reset issue_count", 64'(sel_bus.issue_count), 64'd0);
        chk("reset slot0 entry", 64'(sel_bus.issue_entries[0]), 64'd0);
        chk("reset slot1 entry", 64'(sel_bus.issue_entries[1]), 64'd0);
        chk("reset clear_valid", 64'(sel_bus.issue_clear_valid), 64'd0);
        repeat (2) @(negedge clock);
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Table: vm, rm, grants, mispredict, exp clear_valid, exp idx0, exp idx1.
`ifdef ISSUE_AGE_ORDER_EN
        // Age order for the default ROB pattern: 5,3,1,6,0,4,2,7.
        add(8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd5, 3'd3);
        add(8'h81, 8'h81, 2'b11, 1'b0, 2'b11, 3'd0, 3'd7);
        add(8'h24, 8'h24, 2'b10, 1'b0, 2'b10, 3'd0, 3'd5);
        add(8'h06, 8'h06, 2'b11, 1'b0, 2'b11, 3'd1, 3'd2);
        add(8'hFF, 8'hFF, 2'b11, 1'b1, 2'b00, 3'd0, 3'd0);
        add(8'hFF, 8'hFF, 2'b01, 1'b0, 2'b01, 3'd5, 3'd0);
        add(8'h00, 8'hFF, 2'b11, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'hFF, 8'h00, 2'b11, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'h08, 8'h08, 2'b11, 1'b0, 2'b01, 3'd3, 3'd0);
        add(8'h30, 8'h30, 2'b00, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'h0F, 8'h0F, 2'b10, 1'b0, 2'b10, 3'd0, 3'd3);
        add(8'h84, 8'h84, 2'b11, 1'b0, 2'b11, 3'd2, 3'd7);
`else
        // Round-robin; the pointer trace is 0,2,4,6,0,0,3,3,3,4,4,4,4,4 -> 5.
        add(8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd0, 3'd1);
        add(8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd2, 3'd3);
        add(8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd4, 3'd5);
        add(8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd6, 3'd7);
        add(8'h81, 8'h81, 2'b11, 1'b0, 2'b11, 3'd0, 3'd7);
        add(8'h24, 8'h24, 2'b10, 1'b0, 2'b10, 3'd0, 3'd2);
        add(8'h06, 8'h06, 2'b11, 1'b0, 2'b11, 3'd1, 3'd2);
        add(8'hFF, 8'hFF, 2'b11, 1'b1, 2'b00, 3'd0, 3'd0);
        add(8'hFF, 8'hFF, 2'b01, 1'b0, 2'b01, 3'd3, 3'd0);
        add(8'h00, 8'hFF, 2'b11, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'hFF, 8'h00, 2'b11, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'h08, 8'h08, 2'b11, 1'b0, 2'b01, 3'd3, 3'd0);
        add(8'h30, 8'h30, 2'b00, 1'b0, 2'b00, 3'd0, 3'd0);
        add(8'hFF, 8'hFF, 2'b10, 1'b0, 2'b10, 3'd0, 3'd4);
`endif
        foreach (vecs[n]) begin
            step($sformatf("vec%0d", n), vecs[n].vm, vecs[n].rm, vecs[n].g, vecs[n].mp,
                 vecs[n].ecv, vecs[n].ei0, vecs[n].ei1);
        end

        // Hand sequences with custom ROB fields. These are ignored in round-robin mode.
        rob_i[1] = 5'd5;  rob_w[1] = 1'b0;
        rob_i[6] = 5'd2;  rob_w[6] = 1'b0;
        rob_i[0] = 5'd30; rob_w[0] = 1'b0;
        rob_i[3] = 5'd1;  rob_w[3] = 1'b1;
`ifdef ISSUE_AGE_ORDER_EN
        step("age pair", 8'h42, 8'h42, 2'b11, 1'b0, 2'b11, 3'd6, 3'd1);
        step("age wrap", 8'h09, 8'h09, 2'b01, 1'b0, 2'b01, 3'd0, 3'd0);
        rob_i[2] = 5'd4; rob_w[2] = 1'b0;
        rob_i[6] = 5'd4; rob_w[6] = 1'b0;
        step("age tie", 8'h44, 8'h44, 2'b11, 1'b0, 2'b11, 3'd2, 3'd6);
        rob_i[0] = 5'd2;  rob_w[0] = 1'b1;
        rob_i[3] = 5'd29; rob_w[3] = 1'b0;
        step("age wrap rev", 8'h09, 8'h09, 2'b11, 1'b0, 2'b11, 3'd3, 3'd0);
`else
        step("rr pair", 8'h42, 8'h42, 2'b11, 1'b0, 2'b11, 3'd6, 3'd1);
        step("rr single", 8'h09, 8'h09, 2'b01, 1'b0, 2'b01, 3'd3, 3'd0);
        rob_i[2] = 5'd4; rob_w[2] = 1'b0;
        rob_i[6] = 5'd4; rob_w[6] = 1'b0;
        step("rr wrap", 8'h44, 8'h44, 2'b11, 1'b0, 2'b11, 3'd6, 3'd2);
        rob_i[0] = 5'd2;  rob_w[0] = 1'b1;
        rob_i[3] = 5'd29; rob_w[3] = 1'b0;
        step("rr wrap2", 8'h09, 8'h09, 2'b11, 1'b0, 2'b11, 3'd3, 3'd0);
`endif

        // Reset asserted mid-cycle after a valid issue.
        set_default_rob();
`ifdef ISSUE_AGE_ORDER_EN
        step("pre-reset", 8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd5, 3'd3);
`else
        step("pre-reset", 8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd1, 3'd2);
`endif
        @(negedge clock);
        pop_check("pre-reset reg");
        #2 reset = 1'b1;
        #1;
        chk("mid reset issue_count", 64'(sel_bus.issue_count), 64'd0);
        chk("mid reset slot0 valid", 64'(sel_bus.issue_entries[0].valid), 64'd0);
        chk("mid reset slot1 valid", 64'(sel_bus.issue_entries[1].valid), 64'd0);
        chk("mid reset clear_valid", 64'(sel_bus.issue_clear_valid), 64'd0);
        sb.delete();
        @(negedge clock);
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        @(negedge clock);
        reset = 1'b0;
`ifdef ISSUE_AGE_ORDER_EN
        step("post-reset", 8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd5, 3'd3);
`else
        step("post-reset", 8'hFF, 8'hFF, 2'b11, 1'b0, 2'b11, 3'd0, 3'd1);
`endif
        step("idle", 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clock);
        pop_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
